// File: rtl/io_pkg.sv
// io_pkg: constants shared by the output-port sink, the processor
// integration and the bench.
//   DATA_W         processor word width
//   OUT_FIFO_DEPTH entries in the OUT-instruction FIFO (power of two, >= 2)
//   OUT_FIFO_AW    log2(OUT_FIFO_DEPTH), pointer index width
package io_pkg;
  localparam int DATA_W         = 16;
  localparam int OUT_FIFO_DEPTH = 8;
  localparam int OUT_FIFO_AW    = 3;
endpackage

// File: rtl/out_fifo_mem.sv
// out_fifo_mem: DEPTH x W register array backing the output FIFO.
// Ports:
//   clk    in   system clock, rising edge
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index (asynchronous read)
//   rdata  out  storage[raddr]
// Storage is intentionally not reset.
module out_fifo_mem
  import io_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = OUT_FIFO_DEPTH,
  parameter int AW    = OUT_FIFO_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_out_buffer.sv
// io_out_buffer: output-port sink behind the write-back stage. Every OUT
// result (wr_data qualified by wr_en) is queued in a small FIFO and offered
// to a consumer over valid/ready, so a slow peripheral never stalls the
// pipeline. Writes arriving while full (and not popping) are dropped and
// raise a sticky overflow flag.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   wr_en     in   out strobe from WB, one pulse per OUT
//   wr_data   in   WB write data for that OUT
//   rd_ready  in   consumer accepts rd_data this cycle
//   rd_valid  out  rd_data holds the oldest unread entry
//   rd_data   out  head entry, 0 when empty
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  stored entries, 0..DEPTH
//   overflow  out  sticky drop flag
//   clr_ovf   in   synchronous clear of overflow (a same-cycle drop wins)
module io_out_buffer
  import io_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = OUT_FIFO_DEPTH,
  parameter int AW    = OUT_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_ovf
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] head;
  logic         pop;
  logic         push_ok;
  logic         drop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count    = wr_ptr - rd_ptr;
  assign rd_valid = !empty;
  // Gate the head so unwritten storage never shows up on rd_data.
  assign rd_data  = empty ? '0 : head;

  assign pop     = rd_valid & rd_ready;
  // A pop frees a slot in the same edge, so a full FIFO can still accept.
  assign push_ok = wr_en & (!full | pop);
  assign drop    = wr_en & full & !pop;

  out_fifo_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
